// File: rtl/adc_capture_ctl.sv
// Capture sequencer for a bank of serial ADCs: runs CNV/SCK for one conversion, loads the
// per-ADC shifters into the output chain, then drains the chain one word per valid/ready handshake.
module adc_capture_ctl #(
    parameter int adc_bits    = 24,
    parameter int num_adcs    = 8,
    parameter int cnv_high    = 4,
    parameter int conv_cycles = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_tick,
    output logic adc_cnv,
    output logic adc_sck,
    output logic shift_ena,
    output logic shifter_load_ena,
    output logic ext_load_ena,
    output logic out_valid,
    input  logic out_ready,
    output logic [((num_adcs > 1) ? $clog2(num_adcs) : 1)-1:0] out_channel,
    output logic busy,
    output logic overrun
);

    localparam int CH_W    = (num_adcs > 1) ? $clog2(num_adcs) : 1;
    localparam int CNT_MAX = (conv_cycles > adc_bits) ? conv_cycles : adc_bits;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REM_W   = $clog2(num_adcs + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SHIFT,
        HOLD,
        LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              cnv_q, cnv_d;
    logic              sck_q, sck_d;
    logic              shift_q, shift_d;
    logic              load_q, load_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic              handshake;

    assign handshake = valid_q & out_ready;

    // Next state; SHIFT uses cnt as the bit index and phase_q to split each bit into SCK-high/shift halves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                if (cnt_q == CNT_W'(conv_cycles - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (cnt_q == CNT_W'(adc_bits - 1)) begin
                        state_d = (rem_q == '0) ? LOAD : HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rem_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drain counter and registered outputs, all decoded from next-state values so they align with state_q.
    always_comb begin
        rem_d = rem_q;
        if (state_q == LOAD) begin
            rem_d = REM_W'(num_adcs);
        end else if (handshake) begin
            rem_d = rem_q - 1'b1;
        end
        cnv_d   = (state_d == CONVERT) && (cnt_d < CNT_W'(cnv_high));
        sck_d   = (state_d == SHIFT) && !phase_d;
        shift_d = (state_d == SHIFT) && phase_d;
        load_d  = (state_d == LOAD);
        valid_d = (rem_d != '0);
        chan_d  = (rem_d == '0) ? '0 : CH_W'(num_adcs - int'(rem_d));
        busy_d  = (state_d != IDLE);
        ovr_d   = ovr_q | (sample_tick && (state_q != IDLE));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            rem_q   <= '0;
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            shift_q <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            cnv_q   <= cnv_d;
            sck_q   <= sck_d;
            shift_q <= shift_d;
            load_q  <= load_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // The chain must advance in the same clock as the handshake, so this enable follows out_ready directly.
    assign ext_load_ena     = handshake;
    assign adc_cnv          = cnv_q;
    assign adc_sck          = sck_q;
    assign shift_ena        = shift_q;
    assign shifter_load_ena = load_q;
    assign out_valid        = valid_q;
    assign out_channel      = chan_q;
    assign busy             = busy_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// Bench for adc_capture_ctl: timing-schedule reference model, serial ADC and stage-chain models,
// table-driven timing vectors and directed corner-case sequences.
module tb_adc_capture_ctl;

    localparam int B  = 24;
    localparam int N  = 8;
    localparam int CH = 4;
    localparam int CV = 40;
    localparam int B2 = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    logic sample_tick = 1'b0, out_ready = 1'b0;
    logic adc_cnv, adc_sck, shift_ena, shifter_load_ena, ext_load_ena, out_valid, busy, overrun;
    logic [2:0] out_channel;

    logic tick2 = 1'b0, ready2 = 1'b0;
    logic cnv2, sck2, sh2, ld2, ext2, val2, busy2, ovr2;
    logic [0:0] chan2;

    adc_capture_ctl dut (
        .clock(clock), .reset(reset), .sample_tick(sample_tick),
        .adc_cnv(adc_cnv), .adc_sck(adc_sck), .shift_ena(shift_ena),
        .shifter_load_ena(shifter_load_ena), .ext_load_ena(ext_load_ena),
        .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
        .busy(busy), .overrun(overrun)
    );

    adc_capture_ctl #(.adc_bits(B2), .num_adcs(1), .cnv_high(CH), .conv_cycles(CV)) dut1 (
        .clock(clock), .reset(reset), .sample_tick(tick2),
        .adc_cnv(cnv2), .adc_sck(sck2), .shift_ena(sh2),
        .shifter_load_ena(ld2), .ext_load_ena(ext2),
        .out_valid(val2), .out_ready(ready2), .out_channel(chan2),
        .busy(busy2), .overrun(ovr2)
    );

    int n_chk = 0, n_fail = 0;

    // Reference model: offset since CNV rise, drain count, load pending, sticky overrun.
    bit m_act = 0, m_load = 0, m_ovr = 0;
    int m_k = 0, m_rem = 0, m_holds = 0, m_acc = 0;
    logic [B-1:0] cur_w [N];
    logic [B-1:0] sh_m [N];
    logic [B-1:0] out_m [N];
    logic [B-1:0] exp_q [$];
    int nshift = 0;

    int c_cnv = 0, c_sck = 0, c_sh = 0, c_ld = 0, c_ext = 0, c_both = 0, words_rx = 0;
    bit s_cnv, s_sck, s_sh, s_ld, s_busy, s_val, s_ovr;
    logic [2:0] s_chan;

    typedef struct {
        int off;
        bit cnv, sck, sh, ld, busy, val;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        c_cnv = 0; c_sck = 0; c_sh = 0; c_ld = 0; c_ext = 0; c_both = 0; words_rx = 0;
        m_holds = 0; m_acc = 0;
    endtask

    task automatic step(input bit tick, input bit rdy);
        bit e_val, e_sck, e_sh, nv, novr;
        int e_ch, nrem;
        logic [10:0] ev, av;
        sample_tick = tick;
        out_ready   = rdy;
        @(negedge clock);
        e_val = (m_rem != 0);
        e_ch  = e_val ? N - m_rem : 0;
        e_sck = m_act && m_k >= CV && m_k < CV + 2*B && ((m_k - CV) % 2 == 0);
        e_sh  = m_act && m_k >= CV && m_k < CV + 2*B && ((m_k - CV) % 2 == 1);
        ev = {m_act && m_k < CH, e_sck, e_sh, m_load, e_val && rdy, e_val, m_act, m_ovr, 3'(e_ch)};
        av = {adc_cnv, adc_sck, shift_ena, shifter_load_ena, ext_load_ena, out_valid, busy, overrun, out_channel};
        chk("cycle_outputs", av, ev);
        s_cnv = adc_cnv; s_sck = adc_sck; s_sh = shift_ena; s_ld = shifter_load_ena;
        s_busy = busy; s_val = out_valid; s_ovr = overrun; s_chan = out_channel;
        c_cnv += adc_cnv; c_sck += adc_sck; c_sh += shift_ena; c_ld += shifter_load_ena;
        c_ext += ext_load_ena;
        if (shifter_load_ena && ext_load_ena) c_both++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("word_expected", 0, 1);
            else begin
                chk("word_data", out_m[0], exp_q.pop_front());
                words_rx++;
            end
        end
        if (shifter_load_ena) begin
            for (int i = 0; i < N; i++) out_m[i] = sh_m[i];
        end else if (ext_load_ena) begin
            for (int i = 0; i < N-1; i++) out_m[i] = out_m[i+1];
            out_m[N-1] = '0;
        end
        if (shift_ena && nshift < B) begin
            for (int i = 0; i < N; i++) sh_m[i] = {sh_m[i][B-2:0], cur_w[i][B-1-nshift]};
            nshift++;
        end
        @(posedge clock);
        #1;
        nv   = (m_rem != 0);
        novr = m_ovr | (tick && m_act);
        nrem = m_load ? N : ((nv && rdy) ? m_rem - 1 : m_rem);
        if (!m_act) begin
            if (tick) begin
                m_act = 1; m_k = 0; nshift = 0; m_acc++;
                for (int i = 0; i < N; i++) begin
                    cur_w[i] = B'($urandom);
                    exp_q.push_back(cur_w[i]);
                end
            end
        end else if (m_load) begin
            m_act = 0; m_load = 0;
        end else begin
            if (m_k >= CV + 2*B - 1) begin
                if (m_rem == 0) m_load = 1;
                else m_holds++;
            end
            m_k++;
        end
        m_rem = nrem;
        m_ovr = novr;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1; sample_tick = 1'b0; out_ready = 1'b0;
        #1;
        chk(nm, {adc_cnv, adc_sck, shift_ena, shifter_load_ena, ext_load_ena, out_valid, busy, overrun, out_channel}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        m_act = 0; m_load = 0; m_k = 0; m_rem = 0; m_ovr = 0;
        exp_q.delete();
    endtask

    initial begin
        int idx, ext0, n1_sck, n1_sh, n1_ld, n1_cnv, n1_words, n1_badch, ns2;
        logic [B2-1:0] w2, sh2_m, out2_m;

        tbl[0]  = '{0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1,  1, 0, 0, 0, 1, 0};
        tbl[2]  = '{4,  1, 0, 0, 0, 1, 0};
        tbl[3]  = '{5,  0, 0, 0, 0, 1, 0};
        tbl[4]  = '{40, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{41, 0, 1, 0, 0, 1, 0};
        tbl[6]  = '{42, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{87, 0, 1, 0, 0, 1, 0};
        tbl[8]  = '{88, 0, 0, 1, 0, 1, 0};
        tbl[9]  = '{89, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{90, 0, 0, 0, 0, 0, 1};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_dut1", {cnv2, sck2, sh2, ld2, ext2, val2, busy2, ovr2, chan2}, 0);
        do_reset("reset_state");

        // Reset in the middle of SHIFT with overrun already set.
        step(1, 1);
        repeat (10) step(0, 1);
        step(1, 1);
        repeat (50) step(0, 1);
        chk("pre_reset_busy", s_busy, 1);
        chk("pre_reset_overrun", s_ovr, 1);
        do_reset("reset_mid_shift");

        // One sample, consumer always ready.
        clear_counts();
        step(1, 1);
        repeat (110) step(0, 1);
        chk("t2_cnv_cycles", c_cnv, CH);
        chk("t2_sck_pulses", c_sck, B);
        chk("t2_shift_ena", c_sh, B);
        chk("t2_loads", c_ld, 1);
        chk("t2_ext_loads", c_ext, N);
        chk("t2_words", words_rx, N);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Timing table with consumer stalled.
        idx = 0;
        for (int off = 0; off <= 95; off++) begin
            step(off == 0, 0);
            if (idx < 11 && tbl[idx].off == off) begin
                chk($sformatf("tbl_off%0d", off), {s_cnv, s_sck, s_sh, s_ld, s_busy, s_val},
                    {tbl[idx].cnv, tbl[idx].sck, tbl[idx].sh, tbl[idx].ld, tbl[idx].busy, tbl[idx].val});
                idx++;
            end
        end
        ext0 = c_ext;
        repeat (100) step(0, 0);
        chk("stall_no_ext", c_ext - ext0, 0);
        chk("stall_valid_held", s_val, 1);
        chk("stall_chan0", s_chan, 0);
        repeat (12) step(0, 1);
        chk("stall_drained", exp_q.size(), 0);

        // Second tick during CONVERT.
        do_reset("reset_t5");
        clear_counts();
        step(1, 1);
        repeat (10) step(0, 1);
        step(1, 1);
        step(0, 1);
        chk("t5_overrun_set", s_ovr, 1);
        repeat (110) step(0, 1);
        chk("t5_overrun_sticky", s_ovr, 1);
        chk("t5_one_sample", m_acc, 1);
        chk("t5_words", words_rx, N);
        do_reset("t5_overrun_cleared");

        // Ticks at minimum period, consumer stalled in alternating 90-cycle windows.
        clear_counts();
        for (int c = 0; c < 900; c++) step((c % 90) == 0, (c % 180) >= 90);
        repeat (200) step(0, 1);
        chk("t4_hold_entered", m_holds > 0, 1);
        chk("t4_no_dual_load", c_both, 0);
        chk("t4_words", words_rx, N * m_acc);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Random ticks and backpressure.
        do_reset("reset_rand");
        clear_counts();
        for (int c = 0; c < 3000; c++) step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0);
        repeat (200) step(0, 1);
        chk("rand_no_dual_load", c_both, 0);
        chk("rand_words", words_rx, N * m_acc);
        chk("rand_queue_empty", exp_q.size(), 0);

        // Single-ADC, 16-bit instance.
        n1_sck = 0; n1_sh = 0; n1_ld = 0; n1_cnv = 0; n1_words = 0; n1_badch = 0; ns2 = 0;
        w2 = B2'($urandom); sh2_m = '0; out2_m = '0;
        for (int c = 0; c < 130; c++) begin
            tick2 = (c == 0); ready2 = 1'b1;
            @(negedge clock);
            n1_sck += sck2; n1_sh += sh2; n1_ld += ld2; n1_cnv += cnv2;
            if (chan2 != 1'b0) n1_badch++;
            if (val2 && ready2) begin
                chk("n1_word_data", out2_m, w2);
                n1_words++;
            end
            if (ld2) out2_m = sh2_m;
            if (sh2 && ns2 < B2) begin
                sh2_m = {sh2_m[B2-2:0], w2[B2-1-ns2]};
                ns2++;
            end
            @(posedge clock);
            #1;
        end
        tick2 = 1'b0;
        chk("n1_sck_pulses", n1_sck, B2);
        chk("n1_shift_ena", n1_sh, B2);
        chk("n1_cnv_cycles", n1_cnv, CH);
        chk("n1_loads", n1_ld, 1);
        chk("n1_words", n1_words, 1);
        chk("n1_channel_zero", n1_badch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
